// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI register sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    RESPOND
  } seq_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // One direction bit, then the address, then the register data field.
  function automatic int frame_len(int addr_w, int reg_w);
    return 1 + addr_w + reg_w;
  endfunction

endpackage

// File: rtl/spi_register_sequencer.sv
// Turns register read/write commands into framed half-duplex SPI transactions
// and returns one response per command, with timeout and inter-frame gap.
module spi_register_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 8,
  parameter int ADDR_WIDTH            = 7,
  parameter int REG_WIDTH             = 16,
  parameter int TIMEOUT_CYCLES        = 1024,
  parameter int GAP_CYCLES            = 4
) (
  input  logic                             fabric_clk,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_rw,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [REG_WIDTH-1:0]             cmd_wdata,
  output logic                             transaction_valid,
  input  logic                             transaction_ready,
  output logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  output logic [DATA_WIDTH-1:0]            transaction_data,
  output logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  input  logic                             transaction_done,
  input  logic [DATA_WIDTH-1:0]            transaction_read_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [REG_WIDTH-1:0]             rsp_rdata,
  output logic                             rsp_error,
  output logic                             cfg_error,
  output logic                             stray_done
);

  localparam int FRAME_LEN = frame_len(ADDR_WIDTH, REG_WIDTH);
  localparam int BUILD_W   = (FRAME_LEN > DATA_WIDTH) ? FRAME_LEN : DATA_WIDTH;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic CFG_BAD = (FRAME_LEN > DATA_WIDTH) ||
                             (64'(FRAME_LEN) >= (64'd1 << TRANSACTION_LEN_WIDTH));

  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic                 rw_lat;
  logic [BUILD_W-1:0]   frame_data_wide;
  logic [BUILD_W-1:0]   frame_mask_wide;
  logic [REG_WIDTH-1:0] rd_reg_bits;

  assign transaction_length = TRANSACTION_LEN_WIDTH'(FRAME_LEN);
  assign cfg_error          = CFG_BAD;

  // Frame is built wide enough to never overflow, then cut to the bus width.
  always_comb begin
    frame_data_wide = '0;
    frame_mask_wide = '0;
    frame_data_wide[FRAME_LEN-1] = cmd_rw;
    frame_data_wide[FRAME_LEN-2 -: ADDR_WIDTH] = cmd_addr;
    frame_mask_wide[FRAME_LEN-1 -: ADDR_WIDTH+1] = '1;
    if (cmd_rw == RW_WRITE) begin
      frame_data_wide[REG_WIDTH-1:0] = cmd_wdata;
      frame_mask_wide[REG_WIDTH-1:0] = '1;
    end
  end

  generate
    if (BUILD_W > DATA_WIDTH) begin : g_frame_hi
      logic unused_frame_hi;
      assign unused_frame_hi = ^{frame_data_wide[BUILD_W-1:DATA_WIDTH],
                                 frame_mask_wide[BUILD_W-1:DATA_WIDTH]};
    end
    if (REG_WIDTH <= DATA_WIDTH) begin : g_rd_fit
      assign rd_reg_bits = transaction_read_data[REG_WIDTH-1:0];
      if (REG_WIDTH < DATA_WIDTH) begin : g_rd_hi
        logic unused_rd_hi;
        assign unused_rd_hi = ^transaction_read_data[DATA_WIDTH-1:REG_WIDTH];
      end
    end else begin : g_rd_pad
      assign rd_reg_bits = {{(REG_WIDTH-DATA_WIDTH){1'b0}}, transaction_read_data};
    end
  endgenerate

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      rw_lat              <= RW_WRITE;
      cmd_ready           <= 1'b0;
      transaction_valid   <= 1'b0;
      transaction_data    <= '0;
      transaction_rw_mask <= '0;
      rsp_valid           <= 1'b0;
      rsp_rdata           <= '0;
      rsp_error           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= !CFG_BAD;
          if (cmd_valid && cmd_ready) begin
            cmd_ready           <= 1'b0;
            rw_lat              <= cmd_rw;
            transaction_data    <= frame_data_wide[DATA_WIDTH-1:0];
            transaction_rw_mask <= frame_mask_wide[DATA_WIDTH-1:0];
            transaction_valid   <= 1'b1;
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          if (transaction_ready) begin
            transaction_valid <= 1'b0;
            cnt               <= TIMEOUT_LOAD;
            state             <= WAIT;
          end
        end
        WAIT: begin
          // A done pulse on the terminal-count cycle still counts as success.
          if (transaction_done || cnt == '0) begin
            rsp_error <= !transaction_done;
            rsp_rdata <= (transaction_done && rw_lat == RW_READ) ? rd_reg_bits : '0;
            if (GAP_CYCLES == 0) begin
              rsp_valid <= 1'b1;
              state     <= RESPOND;
            end else begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= !CFG_BAD;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      stray_done <= 1'b0;
    end else if (transaction_done && state != WAIT) begin
      stray_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_register_sequencer.sv
// Randomized bench for spi_register_sequencer against a frame/latency model.
module tb_spi_register_sequencer;

  localparam int DW = 32;
  localparam int TLW = 8;
  localparam int AW = 7;
  localparam int RW = 16;
  localparam int TO = 1024;
  localparam int GP = 4;
  localparam int FL = 1 + AW + RW;

  logic fabric_clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [RW-1:0] cmd_wdata = '0;
  logic transaction_valid, transaction_ready = 1'b0;
  logic [TLW-1:0] transaction_length;
  logic [DW-1:0] transaction_data, transaction_rw_mask;
  logic transaction_done = 1'b0;
  logic [DW-1:0] transaction_read_data = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [RW-1:0] rsp_rdata;
  logic rsp_error, cfg_error, stray_done;

  logic c_cmd_ready, c_tv, c_rsp_valid, c_rsp_error, c_cfg_error, c_stray;
  logic [TLW-1:0] c_len;
  logic [DW-1:0] c_data, c_mask;
  logic [23:0] c_rdata;

  always #5 fabric_clk = ~fabric_clk;

  spi_register_sequencer #(
    .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(TLW), .ADDR_WIDTH(AW), .REG_WIDTH(RW),
    .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)
  ) dut (
    .fabric_clk(fabric_clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .transaction_valid(transaction_valid), .transaction_ready(transaction_ready),
    .transaction_length(transaction_length), .transaction_data(transaction_data),
    .transaction_rw_mask(transaction_rw_mask), .transaction_done(transaction_done),
    .transaction_read_data(transaction_read_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .cfg_error(cfg_error), .stray_done(stray_done)
  );

  spi_register_sequencer #(
    .DATA_WIDTH(32), .TRANSACTION_LEN_WIDTH(8), .ADDR_WIDTH(15), .REG_WIDTH(24)
  ) dut_cfg (
    .fabric_clk(fabric_clk), .reset_n(reset_n),
    .cmd_valid(1'b1), .cmd_ready(c_cmd_ready), .cmd_rw(1'b0),
    .cmd_addr(15'h1234), .cmd_wdata(24'h00ABCD),
    .transaction_valid(c_tv), .transaction_ready(1'b1),
    .transaction_length(c_len), .transaction_data(c_data),
    .transaction_rw_mask(c_mask), .transaction_done(1'b0),
    .transaction_read_data(32'h0),
    .rsp_valid(c_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(c_rdata),
    .rsp_error(c_rsp_error), .cfg_error(c_cfg_error), .stray_done(c_stray)
  );

  typedef struct {
    logic [RW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_data(input bit rw, input int addr, input int wdata);
    longint v;
    v = (rw ? (64'd1 << (AW + RW)) : 64'd0) + longint'(addr) * (64'd1 << RW);
    if (!rw) v = v + longint'(wdata);
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_mask(input bit rw);
    longint v;
    v = ((64'd1 << (AW + 1)) - 1) * (64'd1 << RW);
    if (!rw) v = v + (64'd1 << RW) - 1;
    return v[31:0];
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 0);
    check_eq({tag, "_tv"}, transaction_valid, 0);
    check_eq({tag, "_len"}, transaction_length, FL);
    check_eq({tag, "_data"}, transaction_data, 0);
    check_eq({tag, "_mask"}, transaction_rw_mask, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check_eq({tag, "_rsp_error"}, rsp_error, 0);
    check_eq({tag, "_stray"}, stray_done, 0);
  endtask

  // done_dly < 0 means the engine never answers.
  task automatic do_cmd(input bit rw, input int addr, input int wdata, input int done_dly,
                        input int rd_word, input int rsp_hold);
    int n;
    int exp_lat;
    rsp_t e;
    logic [31:0] ed, em;
    addr  = addr & ((1 << AW) - 1);
    wdata = wdata & ((1 << RW) - 1);
    ed = model_data(rw, addr, wdata);
    em = model_mask(rw);
    e.err   = (done_dly < 0);
    e.rdata = (done_dly >= 0 && rw) ? RW'(rd_word) : '0;
    exp_q.push_back(e);

    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge fabric_clk); n++; end
    check_eq("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = AW'(addr); cmd_wdata = RW'(wdata);
    @(negedge fabric_clk);
    cmd_valid = 1'b0; cmd_rw = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = RW'($urandom);
    check_eq("tv_after_accept", transaction_valid, 1);
    check_eq("cmd_ready_busy", cmd_ready, 0);
    check_eq("t_len", transaction_length, FL);
    check_eq("t_data", transaction_data, ed);
    check_eq("t_mask", transaction_rw_mask, em);
    repeat ($urandom_range(0, 3)) begin
      @(negedge fabric_clk);
      check_eq("tv_held", transaction_valid, 1);
      check_eq("t_data_stable", transaction_data, ed);
      check_eq("t_mask_stable", transaction_rw_mask, em);
    end
    transaction_ready = 1'b1;
    @(negedge fabric_clk);
    transaction_ready = 1'b0;
    check_eq("tv_after_ready", transaction_valid, 0);

    if (done_dly >= 0) begin
      repeat (done_dly) @(negedge fabric_clk);
      transaction_done = 1'b1;
      transaction_read_data = rd_word;
      @(negedge fabric_clk);
      transaction_done = 1'b0;
      transaction_read_data = $urandom;
      exp_lat = GP;
    end else begin
      exp_lat = TO + GP;
    end
    n = 0;
    while (!rsp_valid && n < TO + GP + 20) begin @(negedge fabric_clk); n++; end
    check_eq("rsp_latency", n, exp_lat);

    e = exp_q.pop_front();
    repeat (rsp_hold) begin
      check_eq("rsp_valid_held", rsp_valid, 1);
      check_eq("cmd_ready_while_rsp", cmd_ready, 0);
      @(negedge fabric_clk);
    end
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_rdata", rsp_rdata, e.rdata);
    check_eq("rsp_error", rsp_error, e.err);
    rsp_ready = 1'b1;
    @(negedge fabric_clk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_after_hs", rsp_valid, 0);
    check_eq("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    int cnt_a, cnt_b;
    repeat (3) @(negedge fabric_clk);
    check_reset_values("rst");
    check_eq("cfg_error_ok", cfg_error, 0);
    reset_n = 1'b1;
    check_eq("cmd_ready_at_release", cmd_ready, 0);
    @(negedge fabric_clk);
    check_eq("cmd_ready_first_cycle", cmd_ready, 1);

    do_cmd(1'b0, 'h05, 'hBEEF, 30, $urandom, 0);
    do_cmd(1'b1, 'h12, $urandom, 10, 'h00001234, 2);
    do_cmd(1'b1, $urandom, $urandom, -1, 0, 1);
    do_cmd(1'b1, $urandom, $urandom, TO - 1, 'hABCD5A5A, 0);
    do_cmd(1'b0, $urandom, $urandom, 5, $urandom, 10);
    do_cmd(1'b1, $urandom, $urandom, 0, 'h1357C3C3, 10);
    for (int i = 0; i < 10; i++) begin
      do_cmd(1'($urandom), $urandom, $urandom, $urandom_range(0, 60), $urandom,
             $urandom_range(0, 3));
    end

    // Stray done in IDLE, then reset while waiting for the engine.
    check_eq("stray_before", stray_done, 0);
    transaction_done = 1'b1;
    @(negedge fabric_clk);
    transaction_done = 1'b0;
    check_eq("stray_set", stray_done, 1);
    check_eq("stray_no_rsp", rsp_valid, 0);
    check_eq("stray_still_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h33;
    @(negedge fabric_clk);
    cmd_valid = 1'b0;
    transaction_ready = 1'b1;
    @(negedge fabric_clk);
    transaction_ready = 1'b0;
    repeat (5) @(negedge fabric_clk);
    check_eq("stray_sticky", stray_done, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge fabric_clk);
    reset_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge fabric_clk);
      if (rsp_valid) cnt_a++;
      if (transaction_valid) cnt_b++;
    end
    check_eq("no_rsp_after_rst", cnt_a, 0);
    check_eq("no_tv_after_rst", cnt_b, 0);
    check_eq("stray_cleared", stray_done, 0);
    do_cmd(1'b1, $urandom, $urandom, 7, $urandom, 1);

    check_eq("cfg_error_bad", c_cfg_error, 1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge fabric_clk);
      if (c_cmd_ready) cnt_a++;
      if (c_tv) cnt_b++;
    end
    check_eq("cfg_cmd_ready_low", cnt_a, 0);
    check_eq("cfg_no_tv", cnt_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "bench did not finish");
  end

endmodule
